// File: rtl/cam_frame_writer.sv
// Camera-to-SRAM frame writer with NUM_BUFS ring buffers, single-shot/continuous capture and
// malformed-frame flagging. Define FRAME_CHECKSUM_EN to enable the per-frame data checksum.
module cam_frame_writer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CAM_ADDR_W  = 17,
    parameter int unsigned SRAM_ADDR_W = 19,
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned NUM_BUFS    = 2,
    parameter int unsigned BUF_STRIDE  = 131072
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [CAM_ADDR_W-1:0]  cam_addr,
    input  logic [DATA_W-1:0]      cam_data,
    input  logic                   cam_we,
    output logic                   sram_sel,
    output logic                   sram_we,
    output logic                   sram_oe,
    output logic [DATA_W-1:0]      sram_data,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   busy,
    output logic [1:0]             wr_buf,
    output logic [1:0]             rd_buf,
    output logic                   done,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt,
    output logic [DATA_W-1:0]      checksum
);

    localparam int unsigned           PIXELS    = IMG_W * IMG_H;
    localparam logic [CAM_ADDR_W-1:0] LAST_ADDR = CAM_ADDR_W'(PIXELS - 1);
    localparam logic [1:0]            LAST_BUF  = 2'(NUM_BUFS - 1);

    typedef enum logic [2:0] {StIdle, StArm, StWrite, StWait, StDone} state_t;

    state_t state_q;
    logic   start_q;
    logic   last_q;

    logic                   start_edge;
    logic                   in_range;
    logic                   is_first;
    logic                   is_last;
    logic                   accept;
    logic [1:0]             next_buf;
    logic [SRAM_ADDR_W-1:0] pix_addr;

    assign start_edge = start & ~start_q;
    assign in_range   = (32'(cam_addr) < PIXELS);
    assign is_first   = (cam_addr == '0);
    assign is_last    = (cam_addr == LAST_ADDR);
    assign next_buf   = (wr_buf == LAST_BUF) ? 2'd0 : wr_buf + 2'd1;
    assign pix_addr   = SRAM_ADDR_W'(BUF_STRIDE) * SRAM_ADDR_W'(wr_buf) + SRAM_ADDR_W'(cam_addr);

    // In ARM only a frame-start pixel is taken; the strobe cycle of the last pixel takes nothing.
    assign accept = cam_we && in_range &&
                    (((state_q == StArm) && is_first) ||
                     ((state_q == StWrite) && !last_q) ||
                     (state_q == StWait));

    assign sram_oe = 1'b0;
    assign busy    = (state_q == StArm) || (state_q == StWrite) || (state_q == StWait);

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            last_q    <= 1'b0;
            sram_sel  <= 1'b0;
            sram_we   <= 1'b0;
            sram_data <= '0;
            sram_addr <= '0;
            wr_buf    <= 2'd0;
            rd_buf    <= 2'd0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 16'd0;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            start_q  <= start;
            sram_sel <= 1'b0;
            sram_we  <= 1'b0;
            done     <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q   <= StArm;
                        frame_err <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                StArm, StWait: begin
                    if (cam_we && !in_range) frame_err <= 1'b1;
                end
                StWrite: begin
                    if (last_q) begin
                        state_q   <= StDone;
                        last_q    <= 1'b0;
                        done      <= 1'b1;
                        rd_buf    <= wr_buf;
                        wr_buf    <= next_buf;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        state_q <= StWait;
                        if (cam_we && !in_range) frame_err <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= continuous ? StArm : StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Overrides the state transition above when a pixel is taken.
            if (accept) begin
                state_q   <= StWrite;
                sram_sel  <= 1'b1;
                sram_we   <= 1'b1;
                sram_data <= cam_data;
                sram_addr <= pix_addr;
                last_q    <= is_last;
                if (is_first && (state_q != StArm)) frame_err <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                csum_q    <= is_first ? cam_data : csum_q + cam_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer on a reduced 16x8 frame; SRAM writes are checked against
// a scoreboard queue filled as pixels are driven.
module tb_cam_frame_writer;

    localparam int unsigned IMG_W  = 16;
    localparam int unsigned IMG_H  = 8;
    localparam int unsigned PIXELS = IMG_W * IMG_H;
    localparam int unsigned STRIDE = 131072;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [16:0] cam_addr = '0;
    logic [15:0] cam_data = '0;
    logic        cam_we = 1'b0;
    logic        sram_sel, sram_we, sram_oe, busy, done, frame_err;
    logic [15:0] sram_data, frame_cnt, checksum;
    logic [18:0] sram_addr;
    logic [1:0]  wr_buf, rd_buf;

    cam_frame_writer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_we     (cam_we),
        .sram_sel   (sram_sel),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .sram_data  (sram_data),
        .sram_addr  (sram_addr),
        .busy       (busy),
        .wr_buf     (wr_buf),
        .rd_buf     (rd_buf),
        .done       (done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .checksum   (checksum)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [18:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          done_target = 0;
    int          nframes = 0;
    int          mbuf = 0;
    logic [15:0] csum = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Every strobe must match the oldest outstanding expected write.
    always @(negedge pclk) begin
        if (sram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {13'd0, sram_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {13'd0, sram_addr}, {13'd0, e.addr});
                check("wr_data", {16'd0, sram_data}, {16'd0, e.data});
                check("wr_sel", {31'd0, sram_sel}, 32'd1);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic pix(input int a, input logic [15:0] d, input bit wr);
        cam_addr = a[16:0];
        cam_data = d;
        cam_we   = 1'b1;
        if (wr) begin
            wr_t e;
            e.addr = 19'(mbuf * STRIDE + a);
            e.data = d;
            exp_q.push_back(e);
            csum = (a == 0) ? d : csum + d;
        end
        tick();
        cam_we = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic finish_frame(input bit exp_busy, input bit exp_err);
        int n;
        int nb;
        logic [15:0] exp_ck;
        n  = 0;
        nb = (mbuf + 1) % 2;
        done_target++;
        nframes++;
        while (done_cnt < done_target && n < 20) begin
            tick();
            n++;
        end
        check("done_pulse", done_cnt, done_target);
        check("rd_buf", {30'd0, rd_buf}, mbuf);
        check("wr_buf", {30'd0, wr_buf}, nb);
        check("frame_cnt", {16'd0, frame_cnt}, nframes);
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
`ifdef FRAME_CHECKSUM_EN
        exp_ck = csum;
`else
        exp_ck = 16'd0;
`endif
        check("checksum", {16'd0, checksum}, {16'd0, exp_ck});
        tick();
        check("busy_after_done", {31'd0, busy}, {31'd0, exp_busy});
        mbuf = nb;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_sel", {31'd0, sram_sel}, 32'd0);
        check("rst_we", {31'd0, sram_we}, 32'd0);
        check("rst_oe", {31'd0, sram_oe}, 32'd0);
        check("rst_addr", {13'd0, sram_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bufs", {28'd0, wr_buf, rd_buf}, 32'd0);
        check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_err_done", {30'd0, frame_err, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Single shot, back-to-back pixels, data = address.
        arm();
        check("busy_armed", {31'd0, busy}, 32'd1);
        for (int a = 0; a < PIXELS; a++) pix(a, 16'(a), 1'b1);
        finish_frame(1'b0, 1'b0);

        // Continuous, three frames; continuous drops mid-way through the third.
        continuous = 1'b1;
        arm();
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < PIXELS; a++) begin
                if (f == 2 && a == PIXELS / 2) continuous = 1'b0;
                pix(a, 16'($urandom_range(0, 65535)), 1'b1);
            end
            finish_frame(f < 2, 1'b0);
        end

        // Gapped input: one pixel every third cycle.
        arm();
        for (int a = 0; a < PIXELS; a++) begin
            pix(a, 16'(a * 7 + 3), 1'b1);
            if (a < 4) check("gap_strobe_hi", {31'd0, sram_we}, 32'd1);
            tick();
            if (a < 4) check("gap_strobe_lo", {31'd0, sram_we}, 32'd0);
            tick();
        end
        finish_frame(1'b0, 1'b0);

        // Mid-frame join: pixels before address 0 are dropped.
        arm();
        for (int a = 50; a < PIXELS; a++) pix(a, 16'hDEAD, 1'b0);
        check("join_busy", {31'd0, busy}, 32'd1);
        for (int a = 0; a < PIXELS; a++) pix(a, 16'(a ^ 16'h5A5A), 1'b1);
        finish_frame(1'b0, 1'b0);

        // Out-of-range pixel, then a restart at address 0.
        arm();
        for (int a = 0; a < 50; a++) pix(a, 16'(a + 100), 1'b1);
        pix(80000, 16'hBEEF, 1'b0);
        check("err_oor", {31'd0, frame_err}, 32'd1);
        for (int a = 50; a < 60; a++) pix(a, 16'(a + 100), 1'b1);
        pix(0, 16'h1234, 1'b1);
        check("err_restart", {31'd0, frame_err}, 32'd1);
        for (int a = 1; a < PIXELS; a++) pix(a, 16'(a + 200), 1'b1);
        finish_frame(1'b0, 1'b1);

        // Next start clears the error; reset mid-frame aborts with no done.
        arm();
        check("err_cleared", {31'd0, frame_err}, 32'd0);
        for (int a = 0; a < 60; a++) pix(a, 16'(a), 1'b1);
        rst = 1'b1;
        tick();
        check("mrst_we_sel", {30'd0, sram_we, sram_sel}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_bufs", {28'd0, wr_buf, rd_buf}, 32'd0);
        check("mrst_cnt", {16'd0, frame_cnt}, 32'd0);
        check("mrst_data_addr", {sram_data, 13'd0, sram_addr[18:16]}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("mrst_no_done", done_cnt, done_target);
        check("mrst_done_low", {31'd0, done}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
